// File: rtl/addsub_arbiter_if.sv
// Request/response bundle for addsub_arbiter: per-requester valid/ready with packed
// operands on the request side, and a single tagged result stream on the response side.
interface addsub_arbiter_if #(
  parameter int bit_len = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*bit_len-1:0] req_a;
  logic [NUM_REQ*bit_len-1:0] req_b;
  logic [NUM_REQ-1:0]         req_sel;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [bit_len-1:0]         rsp_sum;
  logic                       rsp_c_out;
  logic                       rsp_ovf;
  logic [ID_W-1:0]            rsp_id;
  logic [15:0]                ovf_count;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_c_out, rsp_ovf, rsp_id, ovf_count
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_c_out, rsp_ovf, rsp_id, ovf_count
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin shared add/subtract unit with registered, id-tagged results.
// Define ADDSUB_SAT_EN to clamp overflowed results to the signed limits.
module addsub_arbiter #(
  parameter int bit_len = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  addsub_arbiter_if.slave   bus
);

  localparam int unsigned NREQ_U = NUM_REQ;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [bit_len-1:0] a_q, a_d, b_q, b_d;
  logic               sel_q, sel_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [bit_len-1:0] rsp_sum_q, rsp_sum_d;
  logic               rsp_c_q, rsp_c_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [15:0]        ovf_count_q, ovf_count_d;

  logic [bit_len-1:0] a_arr [NUM_REQ];
  logic [bit_len-1:0] b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  logic [ID_W-1:0]    grant;
  logic               found;
  int unsigned        idx;

  logic [bit_len-1:0] b_eff;
  logic [bit_len:0]   sum_full;
  logic [bit_len-1:0] sum_low;
  logic               ovf;
  logic [bit_len-1:0] sum_out;

  always_comb begin
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      a_arr[i] = bus.req_a[i*bit_len +: bit_len];
      b_arr[i] = bus.req_b[i*bit_len +: bit_len];
    end
  end

  // Search upward from rr_ptr, wrapping; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NREQ_U) idx = idx - NREQ_U;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  // Overflow = carry into msb XOR carry out of msb; the low sum yields the former.
  always_comb begin
    b_eff    = sel_q ? ~b_q : b_q;
    sum_full = {1'b0, a_q} + {1'b0, b_eff} + {{bit_len{1'b0}}, sel_q};
    sum_low  = {1'b0, a_q[bit_len-2:0]} + {1'b0, b_eff[bit_len-2:0]}
             + {{(bit_len-1){1'b0}}, sel_q};
    ovf      = sum_low[bit_len-1] ^ sum_full[bit_len];
`ifdef ADDSUB_SAT_EN
    if (ovf) sum_out = a_q[bit_len-1] ? {1'b1, {(bit_len-1){1'b0}}}
                                      : {1'b0, {(bit_len-1){1'b1}}};
    else     sum_out = sum_full[bit_len-1:0];
`else
    sum_out  = sum_full[bit_len-1:0];
`endif
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_c_d     = rsp_c_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_id_d    = rsp_id_q;
    ovf_count_d = ovf_count_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[grant] = rst_n;
          state_d  = EXEC;
          a_d      = a_arr[grant];
          b_d      = b_arr[grant];
          sel_d    = bus.req_sel[grant];
          id_d     = grant;
          rr_ptr_d = (grant == ID_W'(NUM_REQ-1)) ? '0 : ID_W'(grant + 1'b1);
        end
      end
      EXEC: begin
        rsp_sum_d   = sum_out;
        rsp_c_d     = sum_full[bit_len];
        rsp_ovf_d   = ovf;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        if (ovf && ovf_count_q != '1) ovf_count_d = ovf_count_q + 16'd1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= 1'b0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_c_q     <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= '0;
      ovf_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_c_q     <= rsp_c_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_id_q    <= rsp_id_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_c_out = rsp_c_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.ovf_count = ovf_count_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (bit_len=8, NUM_REQ=4) with hand-computed expectations.
module tb_addsub_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  addsub_arbiter_if #(.bit_len(8), .NUM_REQ(4)) bus ();

  addsub_arbiter #(.bit_len(8), .NUM_REQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated transaction with rsp_ready held high; starts and ends in IDLE.
  task automatic op(input int id, input logic [7:0] a, input logic [7:0] b, input logic sel,
                    input logic [7:0] es, input logic ec, input logic eo);
    logic [3:0] v;
    v = '0;
    v[id] = 1'b1;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_a[id*8 +: 8] = a;
    bus.req_b[id*8 +: 8] = b;
    bus.req_sel[id] = sel;
    bus.rsp_ready = 1'b1;
    #1 check("op_req_ready", 32'(bus.req_ready), 32'(v));
    @(negedge clk);
    bus.req_valid = '0;
    #1 check("op_exec_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("op_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("op_sum",       32'(bus.rsp_sum),   32'(es));
    check("op_c_out",     32'(bus.rsp_c_out), 32'(ec));
    check("op_ovf",       32'(bus.rsp_ovf),   32'(eo));
    check("op_id",        32'(bus.rsp_id),    32'(id));
    @(negedge clk);
    check("op_retired", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] oh;
    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_sum",       32'(bus.rsp_sum),   32'd0);
    check("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;

    op(0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    op(2, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0);
    op(2, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    op(1, 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    op(3, 8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1);
`else
    op(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op(3, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif
    check("ovf_count_2", 32'(bus.ovf_count), 32'd2);

    // All requesters valid: grants rotate 0,1,2,3,0.
    @(negedge clk);
    bus.req_a     = {4{8'h10}};
    bus.req_b     = {4{8'h01}};
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      oh = '0;
      oh[k % 4] = 1'b1;
      #1 check("rr_grant", 32'(bus.req_ready), 32'(oh));
      @(negedge clk);
      check("rr_exec_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("rr_rsp_id",    32'(bus.rsp_id),    32'(k % 4));
      check("rr_rsp_sum",   32'(bus.rsp_sum),   32'h11);
      check("rr_resp_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = '0;
    check("ovf_count_hold", 32'(bus.ovf_count), 32'd2);

    // Back-pressure: response held for 5 cycles while others wait.
    bus.req_valid = 4'b0100;
    bus.req_a[16 +: 8] = 8'h12;
    bus.req_b[16 +: 8] = 8'h34;
    bus.rsp_ready = 1'b0;
    #1 check("bp_grant", 32'(bus.req_ready), 32'b0100);
    @(negedge clk);
    bus.req_valid = 4'b1011;
    #1 check("bp_exec_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_sum",   32'(bus.rsp_sum),   32'h46);
      check("bp_rsp_id",    32'(bus.rsp_id),    32'd2);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1 check("bp_ready_nopath", 32'(bus.req_ready), 32'd0);
    check("bp_still_valid", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    #1 check("bp_retired", 32'(bus.rsp_valid), 32'd0);
    check("bp_next_grant", 32'(bus.req_ready), 32'b1000);
    bus.req_valid = '0;
    #1;

    // Reset during EXEC discards the operation and resets rr_ptr.
    @(negedge clk);
    bus.req_valid = 4'b0010;
    #1 check("rs_grant", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    bus.req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    check("rs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rs_rsp_sum",   32'(bus.rsp_sum),   32'd0);
    check("rs_rsp_id",    32'(bus.rsp_id),    32'd0);
    check("rs_c_out",     32'(bus.rsp_c_out), 32'd0);
    check("rs_ovf",       32'(bus.rsp_ovf),   32'd0);
    check("rs_ovf_count", 32'(bus.ovf_count), 32'd0);
    check("rs_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rs_no_rsp_1", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("rs_no_rsp_2", 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = 4'hF;
    #1 check("rs_grant_ptr0", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares one add/subtract datapath between `NUM_REQ` requesters through valid/ready handshakes. A round-robin arbiter grants one requester at a time and captures its operands. The block computes `a + b` or `a - b` and returns the registered result, carry and signed-overflow flag, tagged with the requester index. It also keeps a saturating count of overflow events. It sits between requesting datapath clients and the arithmetic unit, replacing ad-hoc direct instantiation.

## Interface
- `bit_len`, 8: operand/result width
- `NUM_REQ`, 4: number of requesters, 2..16
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester tag

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `req_valid` in `NUM_REQ`: per-requester operation valid
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit high
- `req_a` in `NUM_REQ*bit_len`: packed operand a; requester i at `[i*bit_len +: bit_len]`
- `req_b` in `NUM_REQ*bit_len`: packed operand b, same packing
- `req_sel` in `NUM_REQ`: 0 = add, 1 = subtract
- `rsp_valid` out 1: result valid
- `rsp_ready` in 1: consumer accepts result
- `rsp_sum` out `bit_len`: result
- `rsp_c_out` out 1: carry out; for subtract, 1 = no borrow
- `rsp_ovf` out 1: two's-complement overflow
- `rsp_id` out `ID_W`: index of the requester that issued the operation
- `ovf_count` out 16: saturating count of overflowed results

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `grant` = first set bit of `req_valid` searching from `rr_ptr` upward, wrapping at `NUM_REQ-1` to 0.
  - `req_ready[grant]` = 1, combinationally; all other `req_ready` bits = 0.
  - Handshake occurs when `req_valid[i] & req_ready[i]`. On handshake: capture a, b, sel and id; set `rr_ptr` = grant+1 (mod `NUM_REQ`); go to EXEC.
  - No valid request: stay in IDLE.
- **EXEC**
  - Compute `{c, s} = a + (sel ? ~b : b) + sel` at width `bit_len+1`.
  - `ovf` = carry into the msb XOR carry out of the msb.
  - Register s, c, ovf and id into the `rsp_*` outputs; if ovf, increment `ovf_count`, saturating at 0xFFFF.
  - Go to RESP. `req_ready` = 0.
- **RESP**
  - `rsp_valid` = 1. The `rsp_*` outputs stay stable while `rsp_ready` = 0.
  - On `rsp_ready` = 1: go to IDLE. `rsp_valid` drops the next cycle.
  - `req_ready` = 0 throughout.
- Requests that do not get a handshake wait. A requester may drop `req_valid` before its handshake without side effects.
- Widths: b = 0x80 with sel = 1 follows the general overflow rule; no special case.

## Timing
- Reset values: `rsp_valid` 0, `rsp_sum` 0, `rsp_c_out` 0, `rsp_ovf` 0, `rsp_id` 0, `ovf_count` 0, `rr_ptr` 0, state IDLE. `req_ready` = 0 while `rst_n` is low.
- Latency: handshake at rising edge N; `rsp_valid` high from after edge N+1; earliest retire at edge N+2.
- Throughput: at most one operation every 3 cycles when `rsp_ready` is held high.
- A combinational path exists from `req_valid` to `req_ready`. No path exists from `rsp_ready` to `req_ready`.
- Reset asserted in any state: immediate return to reset values. An in-flight operation is discarded and no response is issued.
- `ovf_count` is held at 0xFFFF once saturated; only reset clears it.

## Configuration
- `ADDSUB_SAT_EN` defined: on overflow, `rsp_sum` = 0x7F..F if the true result is positive (a msb = 0), or 0x80..0 if negative (a msb = 1). `rsp_ovf` is still 1 and `rsp_c_out` is unchanged.
- Not defined: `rsp_sum` is the wrapped `bit_len` result.

## Test plan
Parameters: `bit_len` = 8, `NUM_REQ` = 4.
- Req0 a = 0x05, b = 0x03, sel = 0 → sum 0x08, c_out 0, ovf 0, id 0; `rsp_valid` 2 edges after handshake.
- Req2 sel = 1: a = 0x05, b = 0x03 → sum 0x02, c_out 1. Then a = 0x03, b = 0x05 → sum 0xFE, c_out 0, ovf 0, id 2.
- a = 0x7F, b = 0x01 add → ovf 1; sum 0x80, or 0x7F with `ADDSUB_SAT_EN`. Then a = 0x80, b = 0x01 sub → ovf 1; sum 0x7F, or 0x80 with `ADDSUB_SAT_EN`. `ovf_count` = 2.
- All four `req_valid` held high, `rsp_ready` = 1 → grant and `rsp_id` order 0, 1, 2, 3, 0; `req_ready` is one-hot or zero every cycle.
- `rsp_ready` low for 5 cycles in RESP → `rsp_*` outputs stable, `req_ready` = 0 throughout; the response retires on the first cycle `rsp_ready` is high.
- `rst_n` pulsed low during EXEC → all outputs at reset values immediately; no response for the in-flight operation; next request is granted from `rr_ptr` = 0.
